// File: rtl/sweep_pkg.sv
// Shared types and default widths for the stepped phase sweep sequencer.
package sweep_pkg;

    localparam int unsigned PHASE_W_DEF = 8;
    localparam int unsigned DELTA_W_DEF = 4;
    localparam int unsigned DWELL_W_DEF = 16;
    localparam int unsigned STEP_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DWELL = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter that times the hold period of each sweep value.
module sweep_dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expired_c
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - DWELL_W'(1);
        end
    end

    // Loaded with the dwell length on DWELL entry, so a count of 1 marks its last cycle.
    assign expired_c = (count == DWELL_W'(1));

endmodule

// File: rtl/sweep_sequencer.sv
// Drives the phase counter through a preload followed by N dwell-separated +/-delta steps.
// Optional second (return) leg is built only when SWEEP_PINGPONG_EN is defined.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned DELTA_W = DELTA_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF,
    parameter int unsigned STEP_W  = STEP_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] cfg_start,
    input  logic [DELTA_W-1:0] cfg_delta,
    input  logic               cfg_up,
    input  logic               cfg_pingpong,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [STEP_W-1:0]  cfg_steps,
    output logic               cnt_preload,
    output logic [PHASE_W-1:0] cnt_pl_data,
    output logic               cnt_up_dn,
    output logic [DELTA_W-1:0] cnt_delta,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [STEP_W-1:0]  step_idx
);

    state_t state, state_d;

    logic [DELTA_W-1:0] sh_delta;
    logic [DWELL_W-1:0] sh_dwell;
    logic [STEP_W-1:0]  sh_steps;
    logic               dir, dir_d;
    logic [STEP_W-1:0]  step_idx_d;

    logic               capture_c;
    logic               timer_load_c;
    logic               expired_c;
    logic               advance_c;

    logic               preload_d;
    logic [PHASE_W-1:0] pl_data_d;
    logic               up_dn_d;
    logic [DELTA_W-1:0] delta_d;
    logic               busy_d;
    logic               done_d;
    logic               aborted_d;

`ifdef SWEEP_PINGPONG_EN
    logic sh_pingpong;
    logic leg2, leg2_d;
`else
    logic unused_pingpong;
    assign unused_pingpong = cfg_pingpong;
`endif

    sweep_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (timer_load_c),
        .load_val  (sh_dwell),
        .expired_c (expired_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state;
        step_idx_d   = step_idx;
        dir_d        = dir;
        capture_c    = 1'b0;
        timer_load_c = 1'b0;
        advance_c    = 1'b0;
`ifdef SWEEP_PINGPONG_EN
        leg2_d       = leg2;
`endif

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = LOAD;
                    capture_c  = 1'b1;
                    step_idx_d = '0;
                    dir_d      = cfg_up;
`ifdef SWEEP_PINGPONG_EN
                    leg2_d     = 1'b0;
`endif
                end
            end
            LOAD, STEP: begin
                if (sh_dwell != '0) begin
                    state_d      = DWELL;
                    timer_load_c = 1'b1;
                end else begin
                    advance_c = 1'b1;
                end
            end
            DWELL:   advance_c = expired_c;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The current value has been held long enough: step, turn around, or finish.
        if (advance_c) begin
            if (step_idx < sh_steps) begin
                state_d    = STEP;
                step_idx_d = step_idx + STEP_W'(1);
            end
`ifdef SWEEP_PINGPONG_EN
            else if (sh_pingpong && !leg2 && (sh_steps != '0)) begin
                state_d    = STEP;
                leg2_d     = 1'b1;
                dir_d      = !dir;
                step_idx_d = STEP_W'(1);
            end
`endif
            else begin
                state_d = DONE;
            end
        end

        if (abort && (state != IDLE)) begin
            state_d      = IDLE;
            step_idx_d   = step_idx;
            dir_d        = dir;
            timer_load_c = 1'b0;
`ifdef SWEEP_PINGPONG_EN
            leg2_d       = leg2;
`endif
        end

        preload_d = (state_d == LOAD);
        pl_data_d = (state_d == LOAD) ? cfg_start : '0;
        delta_d   = (state_d == STEP) ? sh_delta : '0;
        up_dn_d   = (state_d == STEP) && dir_d;
        busy_d    = (state_d == LOAD) || (state_d == DWELL) || (state_d == STEP);
        done_d    = (state_d == DONE);
        aborted_d = abort && (state != IDLE);
    end

    // State, shadow config and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sh_delta    <= '0;
            sh_dwell    <= '0;
            sh_steps    <= '0;
            dir         <= 1'b0;
            step_idx    <= '0;
            cnt_preload <= 1'b0;
            cnt_pl_data <= '0;
            cnt_up_dn   <= 1'b0;
            cnt_delta   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state    <= state_d;
            dir      <= dir_d;
            step_idx <= step_idx_d;
            if (capture_c) begin
                sh_delta <= cfg_delta;
                sh_dwell <= cfg_dwell;
                sh_steps <= cfg_steps;
            end
            cnt_preload <= preload_d;
            cnt_pl_data <= pl_data_d;
            cnt_up_dn   <= up_dn_d;
            cnt_delta   <= delta_d;
            busy        <= busy_d;
            done        <= done_d;
            aborted     <= aborted_d;
        end
    end

`ifdef SWEEP_PINGPONG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_pingpong <= 1'b0;
            leg2        <= 1'b0;
        end else begin
            leg2 <= leg2_d;
            if (capture_c) begin
                sh_pingpong <= cfg_pingpong;
            end
        end
    end
`endif

endmodule
